// File: rtl/sync_updown_counter_param.sv
// Parametrised up/down counter with programmable modulus (0..MAX_VAL), enable, synchronous
// clear, clamped parallel load, wrap/saturate mode, terminal-count decode and a registered
// wrap pulse. Optional clock-enable prescaler compiled in with SYNC_COUNTER_PRESCALE_EN.
module sync_updown_counter_param #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_VAL  = 2**WIDTH-1,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MaxV = MAX_VAL[WIDTH-1:0];

  // Reject out-of-range configurations at elaboration.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("WIDTH out of range");
  end
  if (MAX_VAL < 1 || (WIDTH < 32 && MAX_VAL > (2**WIDTH - 1))) begin : g_bad_max
    $error("MAX_VAL out of range");
  end
  if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_pre
    $error("PRESCALE out of range");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             step;

`ifdef SYNC_COUNTER_PRESCALE_EN
  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);

  logic [PsW-1:0] ps_q, ps_d;

  // Prescaler advances only on enabled cycles; clear/load restart the tick spacing.
  always_comb begin
    ps_d = ps_q;
    if (clear || load) begin
      ps_d = '0;
    end else if (en) begin
      ps_d = (ps_q == PsLast) ? '0 : ps_q + PsW'(1);
    end
  end

  assign step = en && (ps_q == PsLast);

  // Prescaler state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end
`else
  assign step = en;
`endif

  // Next count and wrap pulse: clear > load > step > hold; bounds compared against MAX_VAL.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_val > MaxV) ? MaxV : load_val;
    end else if (step) begin
      if (up_dn) begin
        if (count_q == MaxV) begin
          if (!sat) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          if (!sat) begin
            count_d = MaxV;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  // Count and wrap registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  // Terminal count follows up_dn combinationally.
  assign tc    = up_dn ? (count_q == MaxV) : (count_q == '0);

endmodule

// File: tb/tb_sync_updown_counter_param.sv
// Bench for sync_updown_counter_param: modulus-16 and modulus-10 instances (plus a
// PRESCALE=3 instance when SYNC_COUNTER_PRESCALE_EN is defined) against a modulo-arithmetic
// reference model.
module tb_sync_updown_counter_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, up_dn = 1'b1, sat = 1'b0, clear = 1'b0, load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] c15, c9;
  logic       tc15, w15, tc9, w9;

  int checks = 0;
  int errors = 0;
  int mc15 = 0, mw15 = 0, ps15 = 0;
  int mc9 = 0, mw9 = 0, ps9 = 0;

  always #5 clk = ~clk;

  sync_updown_counter_param #(.WIDTH(4), .MAX_VAL(15), .PRESCALE(1)) dut15 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat(sat), .clear(clear), .load(load),
    .load_val(load_val), .count(c15), .tc(tc15), .wrap(w15)
  );

  sync_updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1)) dut9 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat(sat), .clear(clear), .load(load),
    .load_val(load_val), .count(c9), .tc(tc9), .wrap(w9)
  );

`ifdef SYNC_COUNTER_PRESCALE_EN
  logic [3:0] cp;
  logic       tcp, wp;
  int mcp = 0, mwp = 0, psp = 0;

  sync_updown_counter_param #(.WIDTH(4), .MAX_VAL(15), .PRESCALE(3)) dutp (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat(sat), .clear(clear), .load(load),
    .load_val(load_val), .count(cp), .tc(tcp), .wrap(wp)
  );
`endif

  // Reference: range 0..m treated as arithmetic modulo m+1, or clamped when saturating.
  task automatic model_step(inout int c, inout int w, inout int ps, input int m, input int pre);
    if (rst) begin
      c = 0; w = 0; ps = 0;
    end else if (clear) begin
      c = 0; w = 0; ps = 0;
    end else if (load) begin
      c = (int'(load_val) > m) ? m : int'(load_val); w = 0; ps = 0;
    end else if (en && ps == pre - 1) begin
      ps = 0;
      w = (!sat && (up_dn ? (c == m) : (c == 0))) ? 1 : 0;
      if (up_dn) c = sat ? ((c + 1 > m) ? m : c + 1) : (c + 1) % (m + 1);
      else       c = sat ? ((c == 0) ? 0 : c - 1) : (c + m) % (m + 1);
    end else begin
      if (en) ps = ps + 1;
      w = 0;
    end
  endtask

  function automatic logic [11:0] exp_vec();
    logic t15, t9;
    t15 = up_dn ? (mc15 == 15) : (mc15 == 0);
    t9  = up_dn ? (mc9 == 9) : (mc9 == 0);
    return {4'(mc15), t15, mw15 != 0, 4'(mc9), t9, mw9 != 0};
  endfunction

  // One clock edge: advance models with the inputs seen at the edge, then settle.
  task automatic tick();
    @(posedge clk);
    model_step(mc15, mw15, ps15, 15, 1);
    model_step(mc9, mw9, ps9, 9, 1);
`ifdef SYNC_COUNTER_PRESCALE_EN
    model_step(mcp, mwp, psp, 15, 3);
`endif
    #1;
  endtask

  task automatic reset_models();
    mc15 = 0; mw15 = 0; ps15 = 0; mc9 = 0; mw9 = 0; ps9 = 0;
`ifdef SYNC_COUNTER_PRESCALE_EN
    mcp = 0; mwp = 0; psp = 0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #8;
    checks++;
    if ({c15, w15, c9, w9} !== 10'd0) begin
      errors++;
      $display("FAIL reset_hold: got %h required 000", {c15, w15, c9, w9});
    end
    #4;
    rst = 1'b0;
    reset_models();
    checks++;
    if ({c15, w15, c9, w9} !== 10'd0) begin
      errors++;
      $display("FAIL reset_release: got %h required 000", {c15, w15, c9, w9});
    end
  endtask

  task automatic test_basic();
    en = 1'b1; up_dn = 1'b1; sat = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++;
      if ({c15, tc15, w15, c9, tc9, w9} !== exp_vec()) begin
        errors++;
        $display("FAIL basic edge %0d: got %h required %h", i, {c15, tc15, w15, c9, tc9, w9},
                 exp_vec());
      end
    end
    checks++;
    if (c15 !== 4'd0 || w15 !== 1'b1) begin
      errors++;
      $display("FAIL basic_wrap: got count %0d wrap %b required 0 1", c15, w15);
    end
    for (int i = 0; i < 3; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (c15 !== 4'd0 || c9 !== 4'd0 || w15 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got %0d %0d %b required 0 0 0", c15, c9, w15);
    end
    rst = 1'b0;
    reset_models();
  endtask

  task automatic test_down();
    en = 1'b0; load = 1'b1; load_val = 4'd2;
    tick();
    load = 1'b0; up_dn = 1'b0; en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if ({c15, tc15, w15, c9, tc9, w9} !== exp_vec()) begin
        errors++;
        $display("FAIL down edge %0d: got %h required %h", i, {c15, tc15, w15, c9, tc9, w9},
                 exp_vec());
      end
    end
    checks++;
    if (c9 !== 4'd8) begin
      errors++;
      $display("FAIL down_mod9: got %0d required 8", c9);
    end
  endtask

  task automatic test_saturate();
    sat = 1'b1; en = 1'b0; load = 1'b1; load_val = 4'd8;
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if ({c15, tc15, w15, c9, tc9, w9} !== exp_vec() || c9 !== 4'd9 || w9 !== 1'b0) begin
        errors++;
        $display("FAIL sat_up edge %0d: got %h required %h", i, {c15, tc15, w15, c9, tc9, w9},
                 exp_vec());
      end
    end
    en = 1'b0; load = 1'b1; load_val = 4'd1;
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if ({c15, tc15, w15, c9, tc9, w9} !== exp_vec() || c9 !== 4'd0) begin
        errors++;
        $display("FAIL sat_down edge %0d: got %h required %h", i,
                 {c15, tc15, w15, c9, tc9, w9}, exp_vec());
      end
    end
    sat = 1'b0;
  endtask

  task automatic test_priority();
    up_dn = 1'b1; en = 1'b1; clear = 1'b1; load = 1'b1; load_val = 4'd5;
    tick();
    checks++;
    if (c9 !== 4'd0 || {c15, tc15, w15, c9, tc9, w9} !== exp_vec()) begin
      errors++;
      $display("FAIL clear_over_load: got %h required %h", {c15, tc15, w15, c9, tc9, w9},
               exp_vec());
    end
    clear = 1'b0; en = 1'b0; load_val = 4'd13;
    tick();
    checks++;
    if (c9 !== 4'd9 || c15 !== 4'd13) begin
      errors++;
      $display("FAIL load_clamp: got %0d/%0d required 9/13", c9, c15);
    end
    en = 1'b1; load_val = 4'd4;
    tick();
    checks++;
    if (c9 !== 4'd4 || {c15, tc15, w15, c9, tc9, w9} !== exp_vec()) begin
      errors++;
      $display("FAIL load_over_step: got %h required %h", {c15, tc15, w15, c9, tc9, w9},
               exp_vec());
    end
    load = 1'b0;
  endtask

  task automatic test_enable();
    logic [3:0] want [4] = '{4'd4, 4'd4, 4'd5, 4'd5};
    en = 1'b0; up_dn = 1'b1; load = 1'b1; load_val = 4'd3;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en = (i % 2 == 0);
      tick();
      checks++;
      if (c9 !== want[i] || w9 !== 1'b0 || {c15, tc15, w15, c9, tc9, w9} !== exp_vec()) begin
        errors++;
        $display("FAIL enable step %0d: got %0d wrap %b required %0d 0", i, c9, w9, want[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(3) != 0);
      up_dn = $urandom_range(1);
      sat = ($urandom_range(3) == 0);
      clear = ($urandom_range(19) == 0);
      load = ($urandom_range(9) == 0);
      load_val = 4'($urandom_range(15));
      tick();
      checks++;
      if ({c15, tc15, w15, c9, tc9, w9} !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc %0d: got %h required %h", i, {c15, tc15, w15, c9, tc9, w9},
                 exp_vec());
      end
`ifdef SYNC_COUNTER_PRESCALE_EN
      checks++;
      if (cp !== 4'(mcp) || wp !== (mwp != 0)) begin
        errors++;
        $display("FAIL random_pre cyc %0d: got %0d/%b required %0d/%0d", i, cp, wp, mcp, mwp);
      end
`endif
      if ($urandom_range(49) == 0) begin
        rst = 1'b1;
        #1;
        reset_models();
        checks++;
        if ({c15, w15, c9, w9} !== 10'd0) begin
          errors++;
          $display("FAIL random_reset cyc %0d: got %h required 000", i, {c15, w15, c9, w9});
        end
        rst = 1'b0;
      end
    end
    clear = 1'b0; load = 1'b0;
  endtask

`ifdef SYNC_COUNTER_PRESCALE_EN
  task automatic test_prescale();
    up_dn = 1'b1; sat = 1'b0; en = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0; en = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      checks++;
      if (cp !== 4'(mcp)) begin
        errors++;
        $display("FAIL prescale edge %0d: got %0d required %0d", i, cp, mcp);
      end
    end
    checks++;
    if (cp !== 4'd3) begin
      errors++;
      $display("FAIL prescale_total: got %0d required 3", cp);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      load = (i == 4);
      load_val = 4'd7;
      tick();
      checks++;
      if (cp !== 4'(mcp)) begin
        errors++;
        $display("FAIL prescale_load edge %0d: got %0d required %0d", i, cp, mcp);
      end
    end
    load = 1'b0;
    checks++;
    if (cp !== 4'd8) begin
      errors++;
      $display("FAIL prescale_restart: got %0d required 8", cp);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_down();
    test_saturate();
    test_priority();
    test_enable();
`ifdef SYNC_COUNTER_PRESCALE_EN
    test_prescale();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
